// File: rtl/kernel_nios2_oci_monitor_responder_if.sv
// Avalon-MM word-access bus between the OCI monitor responder
// and the debug RAM / system interconnect.
interface kernel_nios2_oci_monitor_responder_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/kernel_nios2_oci_monitor_responder.sv
// Sysclk-side JTAG debug responder: turns take_* strobes into single
// Avalon word reads/writes and reports MonDReg/MonAReg/ready/error.
module kernel_nios2_oci_monitor_responder #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [37:0]         jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  kernel_nios2_oci_monitor_responder_if.master bus,
  output logic [31:0]         MonDReg,
  output logic [ADDR_W-1:0]   MonAReg,
  output logic                monitor_ready,
  output logic                monitor_error
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t            state_q, state_n;
  logic              rd_q, rd_n;
  logic              wr_q, wr_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [31:0]       dreg_q, dreg_n;
  logic [ADDR_W-1:0] areg_q, areg_n;
  logic              rdy_q, rdy_n;
  logic              err_q, err_n;
  logic [7:0]        cnt_q, cnt_n;
  logic              inc_q, inc_n;

  logic              any_take;
  logic [7:0]        cnt_inc;
  logic              expire;
  logic [ADDR_W-1:0] jdo_addr;
  logic [ADDR_W-1:0] areg_inc;
  logic              unused;

  assign any_take = take_action_ocimem_a
                  | take_no_action_ocimem_a
                  | take_action_ocimem_b;
  assign cnt_inc  = cnt_q + 8'd1;
  assign expire   = bus.avm_waitrequest && (cnt_inc == TO);
  assign jdo_addr = jdo[17 +: ADDR_W];
  assign areg_inc = areg_q + ADDR_W'(1);
  assign unused   = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_n = state_q;
    rd_n    = rd_q;
    wr_n    = wr_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    dreg_n  = dreg_q;
    areg_n  = areg_q;
    rdy_n   = rdy_q;
    err_n   = err_q;
    cnt_n   = cnt_q;
    inc_n   = inc_q;
    unique case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          areg_n = jdo_addr;
          err_n  = 1'b0;
          if (jdo[35]) begin
            state_n = RD;
            rd_n    = 1'b1;
            addr_n  = jdo_addr;
            rdy_n   = 1'b0;
            cnt_n   = 8'd0;
            inc_n   = 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          state_n = WR;
          wr_n    = 1'b1;
          addr_n  = areg_q;
          wdata_n = jdo[34:3];
          dreg_n  = jdo[34:3];
          rdy_n   = 1'b0;
          err_n   = 1'b0;
          cnt_n   = 8'd0;
        end else if (take_no_action_ocimem_a) begin
          state_n = RD;
          rd_n    = 1'b1;
          addr_n  = areg_q;
          rdy_n   = 1'b0;
          err_n   = 1'b0;
          cnt_n   = 8'd0;
          inc_n   = 1'b1;
        end
      end
      RD, WR: begin
        // A command while busy is flagged but never disturbs the access.
        if (any_take) err_n = 1'b1;
        if (!bus.avm_waitrequest) begin
          if (state_q == RD) begin
            dreg_n = bus.avm_readdata;
            if (inc_q) areg_n = areg_inc;
          end else begin
            areg_n = areg_inc;
          end
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          rdy_n   = 1'b1;
          state_n = IDLE;
        end else if (expire) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          rdy_n   = 1'b1;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = IDLE;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        rdy_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dreg_q  <= '0;
      areg_q  <= '0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      dreg_q  <= dreg_n;
      areg_q  <= areg_n;
      rdy_q   <= rdy_n;
      err_q   <= err_n;
      cnt_q   <= cnt_n;
      inc_q   <= inc_n;
    end
  end

  assign bus.avm_address   = addr_q;
  assign bus.avm_read      = rd_q;
  assign bus.avm_write     = wr_q;
  assign bus.avm_writedata = wdata_q;
  assign MonDReg           = dreg_q;
  assign MonAReg           = areg_q;
  assign monitor_ready     = rdy_q;
  assign monitor_error     = err_q;

endmodule

// File: tb/tb_kernel_nios2_oci_monitor_responder.sv
// Randomized bench for the OCI monitor responder: a memory-level
// reference model predicts every bus access and register result.
module tb_kernel_nios2_oci_monitor_responder;
  localparam int AW = 9;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [37:0]   jdo = '0;
  logic          t_a = 1'b0;
  logic          t_na = 1'b0;
  logic          t_b = 1'b0;
  logic [31:0]   mon_d;
  logic [AW-1:0] mon_a;
  logic          rdy;
  logic          err;

  kernel_nios2_oci_monitor_responder_if #(.ADDR_W(AW)) bus ();

  kernel_nios2_oci_monitor_responder #(
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (t_a),
    .take_no_action_ocimem_a(t_na),
    .take_action_ocimem_b   (t_b),
    .bus                    (bus),
    .MonDReg                (mon_d),
    .MonAReg                (mon_a),
    .monitor_ready          (rdy),
    .monitor_error          (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int a);
    if (a == 'h010) return 32'hDEADBEEF;
    return (32'h9E3779B9 * 32'(a + 1)) ^ 32'h5A5A0F0F;
  endfunction

  // Slave memory with programmable stall and an access log.
  logic [31:0]   smem [512];
  logic          swr [512];
  int            stall_req = 0;
  bit            stall_forever = 1'b0;
  int            stall_seen;
  int            obs_kind [1024];
  logic [AW-1:0] obs_addr [1024];
  logic [31:0]   obs_data [1024];
  int            obs_wr;
  logic          req;

  assign req = bus.avm_read | bus.avm_write;
  assign bus.avm_waitrequest = stall_forever || (stall_seen < stall_req);
  assign bus.avm_readdata = swr[bus.avm_address] ? smem[bus.avm_address]
                          : init_val(int'(bus.avm_address));

  initial begin
    for (int i = 0; i < 512; i++) swr[i] = 1'b0;
    stall_seen = 0;
    obs_wr = 0;
    forever begin
      @(posedge clk);
      if (req && !bus.avm_waitrequest) begin
        obs_kind[obs_wr % 1024] <= bus.avm_write ? 2 : 1;
        obs_addr[obs_wr % 1024] <= bus.avm_address;
        obs_data[obs_wr % 1024] <= bus.avm_write ? bus.avm_writedata
                                                 : bus.avm_readdata;
        obs_wr <= obs_wr + 1;
        if (bus.avm_write) begin
          smem[bus.avm_address] <= bus.avm_writedata;
          swr[bus.avm_address]  <= 1'b1;
        end
        stall_seen <= 0;
      end else if (req) begin
        stall_seen <= stall_seen + 1;
      end else begin
        stall_seen <= 0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [31:0]   mmem [512];
  logic [AW-1:0] m_a;
  logic [31:0]   m_d;
  logic          m_e;
  int            exp_kind [$];
  logic [AW-1:0] exp_addr [$];
  logic [31:0]   exp_data [$];
  int            obs_rd = 0;

  task automatic strobe(int k);
    t_a  = (k == 0);
    t_na = (k == 1);
    t_b  = (k == 2);
  endtask

  task automatic strobe_off();
    t_a  = 1'b0;
    t_na = 1'b0;
    t_b  = 1'b0;
  endtask

  task automatic model_read(logic [AW-1:0] a);
    exp_kind.push_back(1);
    exp_addr.push_back(a);
    exp_data.push_back(mmem[a]);
    m_d = mmem[a];
  endtask

  task automatic check_state(string tag);
    chk({tag, "_areg"}, 32'(mon_a), 32'(m_a));
    chk({tag, "_dreg"}, mon_d, m_d);
    chk({tag, "_err"}, 32'(err), 32'(m_e));
    chk({tag, "_rdy"}, 32'(rdy), 32'd1);
    chk({tag, "_req"}, 32'({bus.avm_read, bus.avm_write}), 32'd0);
    chk({tag, "_nacc"}, 32'(obs_wr - obs_rd), 32'(exp_kind.size()));
    while (obs_rd < obs_wr && exp_kind.size() > 0) begin
      chk({tag, "_kind"}, 32'(obs_kind[obs_rd % 1024]), 32'(exp_kind.pop_front()));
      chk({tag, "_addr"}, 32'(obs_addr[obs_rd % 1024]), 32'(exp_addr.pop_front()));
      chk({tag, "_data"}, obs_data[obs_rd % 1024], exp_data.pop_front());
      obs_rd++;
    end
    obs_rd = obs_wr;
    exp_kind.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  // kind: 0 = load address (rd optional), 1 = read next, 2 = write next
  task automatic run_cmd(string tag, int kind, logic [AW-1:0] addr, bit rd,
                         logic [31:0] data, int stall, bit hang, bit inject);
    logic [37:0] j;
    bit          access;
    int          lat;
    int          exp_lat;
    j = 38'({$urandom(), $urandom()});
    if (kind == 0) begin
      j[17 +: AW] = addr;
      j[35] = rd;
    end
    if (kind == 2) j[34:3] = data;
    stall_req = stall;
    stall_forever = hang;
    @(negedge clk);
    jdo = j;
    strobe(kind);
    @(negedge clk);
    strobe_off();
    jdo = 38'({$urandom(), $urandom()});
    access = (kind != 0) || rd;
    m_e = 1'b0;
    case (kind)
      0: begin
        m_a = addr;
        if (rd && !hang) model_read(addr);
      end
      1: begin
        if (!hang) begin
          model_read(m_a);
          m_a = m_a + 1'b1;
        end
      end
      default: begin
        m_d = data;
        if (!hang) begin
          exp_kind.push_back(2);
          exp_addr.push_back(m_a);
          exp_data.push_back(data);
          mmem[m_a] = data;
          m_a = m_a + 1'b1;
        end
      end
    endcase
    if (access && (hang || inject)) m_e = 1'b1;
    if (!access) begin
      chk({tag, "_idle_rdy"}, 32'(rdy), 32'd1);
    end else begin
      chk({tag, "_busy_rdy"}, 32'(rdy), 32'd0);
      exp_lat = hang ? TO : stall + 1;
      lat = 0;
      while (!rdy && lat < TO + 20) begin
        if (inject && lat == 0) begin
          jdo = 38'({$urandom(), $urandom()});
          strobe($urandom_range(0, 2));
        end else begin
          strobe_off();
        end
        @(negedge clk);
        lat++;
      end
      strobe_off();
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    end
    check_state(tag);
    stall_forever = 1'b0;
    stall_req = 0;
  endtask

  initial begin
    int kind;
    int st;
    bit hg;
    bit inj;
    for (int i = 0; i < 512; i++) mmem[i] = init_val(i);
    m_a = '0;
    m_d = '0;
    m_e = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dreg", mon_d, 32'd0);
    chk("rst_areg", 32'(mon_a), 32'd0);
    chk("rst_req", 32'({bus.avm_read, bus.avm_write}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_state("post_rst");

    run_cmd("rd010", 0, 9'h010, 1'b1, 32'd0, 0, 1'b0, 1'b0);
    chk("rd010_val", mon_d, 32'hDEADBEEF);
    run_cmd("ld1ff", 0, 9'h1FF, 1'b0, 32'd0, 0, 1'b0, 1'b0);
    run_cmd("wr1ff", 2, 9'h000, 1'b0, 32'h12345678, 2, 1'b0, 1'b0);
    chk("wr1ff_wrap", 32'(mon_a), 32'h000);
    run_cmd("ld020", 0, 9'h020, 1'b0, 32'd0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_cmd("nxt", 1, 9'h000, 1'b0, 32'd0, i, 1'b0, 1'b0);
    chk("nxt_areg", 32'(mon_a), 32'h023);
    run_cmd("tmo_rd", 0, 9'h055, 1'b1, 32'd0, 0, 1'b1, 1'b0);
    run_cmd("busy", 1, 9'h000, 1'b0, 32'd0, 5, 1'b0, 1'b1);
    run_cmd("clr", 0, 9'h100, 1'b0, 32'd0, 0, 1'b0, 1'b0);
    run_cmd("tmo_wr", 2, 9'h000, 1'b0, 32'hCAFEF00D, 0, 1'b1, 1'b0);

    // Reset in the middle of a stalled write.
    stall_forever = 1'b1;
    @(negedge clk);
    jdo = 38'({$urandom(), $urandom()});
    strobe(2);
    @(negedge clk);
    strobe_off();
    repeat (3) @(negedge clk);
    chk("mid_wr_active", 32'(bus.avm_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_write", 32'(bus.avm_write), 32'd0);
    chk("mid_rst_addr", 32'(bus.avm_address), 32'd0);
    chk("mid_rst_wdata", bus.avm_writedata, 32'd0);
    m_a = '0;
    m_d = '0;
    m_e = 1'b0;
    check_state("mid_rst");
    @(negedge clk);
    stall_forever = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_state("mid_rel");

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      st   = $urandom_range(0, 4);
      hg   = ($urandom_range(0, 24) == 0);
      inj  = (st >= 2 || hg) && ($urandom_range(0, 3) == 0);
      run_cmd("rnd", kind, AW'($urandom()), 1'($urandom()), $urandom(),
              st, hg, inj);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
